// File: rtl/bus_demux_regbank_pkg.sv
// rtl/bus_demux_regbank_pkg.sv - shared widths, stage states and flat-slice helper
package bus_demux_regbank_pkg;

    localparam int DATA_W_DEF   = 32;
    localparam int NUM_DEST_DEF = 32;
    localparam int SEL_W_DEF    = 5;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } stage_state_e;

    // Low bit of register k inside a flat bank vector; the read mux uses the same mapping.
    function automatic int flat_lo(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/bus_demux_regbank_if.sv
// rtl/bus_demux_regbank_if.sv - write request handshake bundle
interface bus_demux_regbank_if
    import bus_demux_regbank_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int SEL_W  = SEL_W_DEF
) ();

    logic              wr_valid;
    logic              wr_ready;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output wr_valid,
        output wr_sel,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_sel,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/bus_demux_regbank_dest_decoder.sv
// rtl/bus_demux_regbank_dest_decoder.sv - select-to-one-hot decoder with enable and range flag
module bus_demux_regbank_dest_decoder
    import bus_demux_regbank_pkg::*;
#(
    parameter int SEL_W    = SEL_W_DEF,
    parameter int NUM_DEST = NUM_DEST_DEF
) (
    input  logic [SEL_W-1:0]    sel,
    input  logic                en,
    output logic [NUM_DEST-1:0] onehot,
    output logic                out_of_range
);

    always_comb begin
        onehot = '0;
        for (int k = 0; k < NUM_DEST; k++) begin
            if (en && (sel == SEL_W'(k))) begin
                onehot[k] = 1'b1;
            end
        end
        // Extra headroom bit so NUM_DEST == 2**SEL_W compares correctly.
        out_of_range = en && ({1'b0, sel} >= (SEL_W + 1)'(NUM_DEST));
    end

endmodule

// File: rtl/bus_demux_regbank.sv
// rtl/bus_demux_regbank.sv - single-entry write stage demuxed into a flat-exported register bank
module bus_demux_regbank
    import bus_demux_regbank_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NUM_DEST   = NUM_DEST_DEF,
    parameter int SEL_W      = SEL_W_DEF,
    parameter bit ZERO_DEST0 = 1'b1
) (
    input  logic                         clk,
    input  logic                         clr,
    bus_demux_regbank_if.slave           wr,
    input  logic                         commit_en,
    output logic [NUM_DEST-1:0]          dest_ld,
    output logic                         pend_valid,
    output logic [SEL_W-1:0]             pend_sel,
    output logic [NUM_DEST*DATA_W-1:0]   regs_flat,
    output logic                         sel_err,
    output logic [15:0]                  wr_count
);

    localparam logic [NUM_DEST-1:0] ZERO_MASK = ZERO_DEST0 ? NUM_DEST'(1) : '0;

    stage_state_e        state_q, state_d;
    logic [SEL_W-1:0]    pend_sel_q, pend_sel_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic [DATA_W-1:0]   regs_q [NUM_DEST];
    logic [DATA_W-1:0]   regs_d [NUM_DEST];
    logic [NUM_DEST-1:0] dest_ld_q, dest_ld_d;
    logic                sel_err_q, sel_err_d;
    logic [15:0]         wr_count_q, wr_count_d;

    logic                accept;
    logic                commit;
    logic [NUM_DEST-1:0] dec_onehot;
    logic                dec_oor;
    logic [NUM_DEST-1:0] load_vec;

    assign wr.wr_ready = (state_q == ST_EMPTY) || commit_en;
    assign accept      = wr.wr_valid && wr.wr_ready;
    assign commit      = (state_q == ST_FULL) && commit_en;

    bus_demux_regbank_dest_decoder #(
        .SEL_W    (SEL_W),
        .NUM_DEST (NUM_DEST)
    ) u_dest_decoder (
        .sel          (pend_sel_q),
        .en           (commit),
        .onehot       (dec_onehot),
        .out_of_range (dec_oor)
    );

    // A hardwired-zero destination consumes the commit without loading or counting.
    assign load_vec = dec_onehot & ~ZERO_MASK;

    always_comb begin
        state_d     = state_q;
        pend_sel_d  = pend_sel_q;
        pend_data_d = pend_data_q;
        regs_d      = regs_q;
        dest_ld_d   = load_vec;
        sel_err_d   = sel_err_q | dec_oor;
        wr_count_d  = wr_count_q + {15'd0, |load_vec};

        for (int k = 0; k < NUM_DEST; k++) begin
            if (load_vec[k]) begin
                regs_d[k] = pend_data_q;
            end
        end

        if (accept) begin
            pend_sel_d  = wr.wr_sel;
            pend_data_d = wr.wr_data;
        end

        case (state_q)
            ST_EMPTY: if (accept) state_d = ST_FULL;
            ST_FULL:  if (commit && !accept) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_EMPTY;
            pend_sel_q  <= '0;
            pend_data_q <= '0;
            dest_ld_q   <= '0;
            sel_err_q   <= 1'b0;
            wr_count_q  <= '0;
            for (int k = 0; k < NUM_DEST; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            state_q     <= state_d;
            pend_sel_q  <= pend_sel_d;
            pend_data_q <= pend_data_d;
            dest_ld_q   <= dest_ld_d;
            sel_err_q   <= sel_err_d;
            wr_count_q  <= wr_count_d;
            regs_q      <= regs_d;
        end
    end

    assign pend_valid = (state_q == ST_FULL);
    assign pend_sel   = pend_sel_q;
    assign dest_ld    = dest_ld_q;
    assign sel_err    = sel_err_q;
    assign wr_count   = wr_count_q;

    for (genvar k = 0; k < NUM_DEST; k++) begin : g_flat
        assign regs_flat[flat_lo(k, DATA_W) +: DATA_W] = regs_q[k];
    end

endmodule

// File: tb/tb_bus_demux_regbank.sv
// tb/tb_bus_demux_regbank.sv - randomized and directed bench against a behavioural bank model
module tb_bus_demux_regbank;

    logic        clk = 1'b0;
    logic        clr;
    logic        valid;
    logic [4:0]  sel;
    logic [31:0] data;
    logic        ce;

    always #5 clk = ~clk;

    bus_demux_regbank_if #(.DATA_W(32), .SEL_W(5)) if_a ();
    bus_demux_regbank_if #(.DATA_W(32), .SEL_W(5)) if_b ();

    assign if_a.wr_valid = valid;
    assign if_a.wr_sel   = sel;
    assign if_a.wr_data  = data;
    assign if_b.wr_valid = valid;
    assign if_b.wr_sel   = sel;
    assign if_b.wr_data  = data;

    logic [31:0]     ld_a, ld_b_raw;
    logic [23:0]     ld_b;
    logic            pv_a, pv_b, err_a, err_b;
    logic [4:0]      ps_a, ps_b;
    logic [15:0]     cnt_a, cnt_b;
    logic [32*32-1:0] flat_a;
    logic [24*32-1:0] flat_b;

    assign ld_b_raw = {8'd0, ld_b};

    bus_demux_regbank #(.DATA_W(32), .NUM_DEST(32), .SEL_W(5), .ZERO_DEST0(1'b1)) u_a (
        .clk(clk), .clr(clr), .wr(if_a.slave), .commit_en(ce),
        .dest_ld(ld_a), .pend_valid(pv_a), .pend_sel(ps_a),
        .regs_flat(flat_a), .sel_err(err_a), .wr_count(cnt_a)
    );

    bus_demux_regbank #(.DATA_W(32), .NUM_DEST(24), .SEL_W(5), .ZERO_DEST0(1'b1)) u_b (
        .clk(clk), .clr(clr), .wr(if_b.slave), .commit_en(ce),
        .dest_ld(ld_b), .pend_valid(pv_b), .pend_sel(ps_b),
        .regs_flat(flat_b), .sel_err(err_b), .wr_count(cnt_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Behavioural model: one optional pending write, plus per-bank contents and status.
    bit          m_pend;
    int          m_psel;
    logic [31:0] m_pdata;
    logic [31:0] m_regs [2][32];
    logic [15:0] m_cnt [2];
    bit          m_err [2];
    logic [31:0] m_ld  [2];
    int          m_nd  [2] = '{32, 24};

    task automatic model_reset();
        m_pend = 0; m_psel = 0; m_pdata = '0;
        for (int d = 0; d < 2; d++) begin
            m_cnt[d] = '0; m_err[d] = 0; m_ld[d] = '0;
            for (int k = 0; k < 32; k++) m_regs[d][k] = '0;
        end
    endtask

    task automatic check_all(input string ph);
        check({ph, "_pv_a"}, 64'(pv_a), 64'(m_pend));
        check({ph, "_pv_b"}, 64'(pv_b), 64'(m_pend));
        if (m_pend) begin
            check({ph, "_ps_a"}, 64'(ps_a), 64'(m_psel));
            check({ph, "_ps_b"}, 64'(ps_b), 64'(m_psel));
        end
        check({ph, "_ld_a"},  64'(ld_a),     64'(m_ld[0]));
        check({ph, "_ld_b"},  64'(ld_b_raw), 64'(m_ld[1]));
        check({ph, "_cnt_a"}, 64'(cnt_a),    64'(m_cnt[0]));
        check({ph, "_cnt_b"}, 64'(cnt_b),    64'(m_cnt[1]));
        check({ph, "_err_a"}, 64'(err_a),    64'(m_err[0]));
        check({ph, "_err_b"}, 64'(err_b),    64'(m_err[1]));
        for (int k = 0; k < 32; k++)
            check($sformatf("%s_a_reg%0d", ph, k), 64'(flat_a[k*32 +: 32]), 64'(m_regs[0][k]));
        for (int k = 0; k < 24; k++)
            check($sformatf("%s_b_reg%0d", ph, k), 64'(flat_b[k*32 +: 32]), 64'(m_regs[1][k]));
    endtask

    // Drive one cycle's inputs from the negedge, clock it, then compare against the model.
    task automatic step(input string ph, input bit v, input int s, input logic [31:0] dt, input bit c);
        bit rdy, acc, com;
        valid = v; sel = 5'(s); data = dt; ce = c;
        #1;
        rdy = !m_pend || c;
        check({ph, "_rdy_a"}, 64'(if_a.wr_ready), 64'(rdy));
        check({ph, "_rdy_b"}, 64'(if_b.wr_ready), 64'(rdy));
        @(posedge clk);
        acc = v && rdy;
        com = m_pend && c;
        for (int d = 0; d < 2; d++) begin
            m_ld[d] = '0;
            if (com) begin
                if (m_psel >= m_nd[d]) m_err[d] = 1;
                else if (m_psel != 0) begin
                    m_regs[d][m_psel] = m_pdata;
                    m_ld[d] = 32'd1 << m_psel;
                    m_cnt[d] = m_cnt[d] + 16'd1;
                end
            end
        end
        if (acc) begin
            m_pend = 1; m_psel = s; m_pdata = dt;
        end else if (com) begin
            m_pend = 0;
        end
        #1;
        check_all(ph);
        @(negedge clk);
    endtask

    task automatic do_reset();
        valid = 0; sel = '0; data = '0; ce = 0;
        clr = 1'b1;
        #1;
        model_reset();
        check("rst_rdy_a", 64'(if_a.wr_ready), 64'd1);
        check_all("rst");
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        valid = 0; sel = '0; data = '0; ce = 0; clr = 1'b1;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single write, one-cycle commit latency.
        step("w1", 1, 5, 32'hDEADBEEF, 1);
        step("w1c", 0, 0, 32'h0, 1);
        check("w1_reg5", 64'(flat_a[5*32 +: 32]), 64'hDEADBEEF);
        check("w1_ld",   64'(ld_a), 64'h20);
        step("w1i", 0, 0, 32'h0, 1);
        check("w1_ld_gone", 64'(ld_a), 64'h0);

        // Stall with a second write waiting, then release.
        step("st1", 1, 3, 32'h11, 0);
        step("st2", 1, 4, 32'h22, 0);
        check("st_reg3_held", 64'(flat_a[3*32 +: 32]), 64'h0);
        step("st3", 1, 4, 32'h22, 1);
        step("st4", 0, 0, 32'h0, 1);
        check("st_reg4", 64'(flat_a[4*32 +: 32]), 64'h22);

        // Streaming all destinations at full rate.
        do_reset();
        for (int k = 0; k < 32; k++) step("str", 1, k, 32'(k) * 32'h01010101, 1);
        step("str_end", 0, 0, 32'h0, 1);
        check("str_cnt_a", 64'(cnt_a), 64'd31);
        check("str_cnt_b", 64'(cnt_b), 64'd23);

        // Same destination back-to-back.
        step("hz1", 1, 7, 32'hA, 1);
        step("hz2", 1, 7, 32'hB, 1);
        step("hz3", 0, 0, 32'h0, 1);
        check("hz_reg7", 64'(flat_a[7*32 +: 32]), 64'hB);

        // Out of range on the 24-entry bank, sticky through later writes.
        step("oor1", 1, 30, 32'h1234, 1);
        step("oor2", 1, 2, 32'h5678, 1);
        step("oor3", 0, 0, 32'h0, 1);
        check("oor_err_b", 64'(err_b), 64'd1);

        // Asynchronous reset between edges with a stalled pending write.
        step("mr1", 1, 9, 32'h55, 0);
        #2;
        clr = 1'b1;
        #1;
        check("mr_pv_a", 64'(pv_a), 64'd0);
        check("mr_reg9", 64'(flat_a[9*32 +: 32]), 64'd0);
        check("mr_rdy",  64'(if_a.wr_ready), 64'd1);
        model_reset();
        @(negedge clk);
        clr = 1'b0;
        for (int i = 0; i < 3; i++) step("mr_post", 0, 0, 32'h0, 1);
        check("mr_reg9_after", 64'(flat_a[9*32 +: 32]), 64'd0);

        // Randomized traffic.
        for (int i = 0; i < 300; i++)
            step("rnd", 1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), $urandom,
                 $urandom_range(0, 3) != 0);
        for (int i = 0; i < 2; i++) step("drain", 0, 0, 32'h0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
